// File: rtl/des_round_ctrl_if.sv
// Command/control bundle between the block-level command port, the DES
// round controller and the round datapath (L/R regs, f-function, key schedule).
// master = command side plus datapath consumer, slave = the round controller.
interface des_round_ctrl_if #(
  parameter int IDX_W = 4
);
  // command side
  logic             start;
  logic             mode;
  logic             hold;
  logic             out_ready;
  logic             in_ready;
  logic             busy;
  logic             out_valid;
  // datapath control
  logic             load_init;
  logic             key_load;
  logic             round_en;
  logic [IDX_W-1:0] round_idx;
  logic [1:0]       key_shift;
  logic             key_dir;
  logic             final_cap;

  modport master (
    output start, mode, hold, out_ready,
    input  in_ready, busy, out_valid,
    input  load_init, key_load, round_en, round_idx, key_shift, key_dir, final_cap
  );

  modport slave (
    input  start, mode, hold, out_ready,
    output in_ready, busy, out_valid,
    output load_init, key_load, round_en, round_idx, key_shift, key_dir, final_cap
  );
endinterface

// File: rtl/des_round_ctrl.sv
// Sequencer for the iterative DES datapath: load, ROUNDS Feistel rounds, final capture, result handshake.
// Latency: start accepted to out_valid is ROUNDS+2 cycles, plus one cycle per cycle of hold in ROUND.
// Backpressure: hold stalls rounds in place; result held in DONE until out_ready; start only taken in IDLE.
module des_round_ctrl #(
  parameter int ROUNDS = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  des_round_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dir_q, dir_d;

  logic             in_ready_c;
  logic             busy_c;
  logic             out_valid_c;
  logic             load_init_c;
  logic             key_load_c;
  logic             round_en_c;
  logic [IDX_W-1:0] round_idx_c;
  logic [1:0]       key_shift_c;
  logic             final_cap_c;

  // Rotation schedule. Decrypt rotates right and skips the rotate in round 0
  // because the key register already holds K16's pre-rotation state after PC-1.
  function automatic logic [1:0] shift_amt(input logic dir, input logic [IDX_W-1:0] idx);
    logic single;
    single = (idx == IDX_W'(0)) || (idx == IDX_W'(1)) ||
             (idx == IDX_W'(8)) || (idx == IDX_W'(15));
    if (dir && (idx == IDX_W'(0))) begin
      shift_amt = 2'd0;
    end else if (single) begin
      shift_amt = 2'd1;
    end else begin
      shift_amt = 2'd2;
    end
  endfunction

  // State, round counter and latched direction; reset drops straight to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state and Moore-style strobes; round_en alone also depends on hold.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dir_d       = dir_q;
    in_ready_c  = 1'b0;
    busy_c      = 1'b1;
    out_valid_c = 1'b0;
    load_init_c = 1'b0;
    key_load_c  = 1'b0;
    round_en_c  = 1'b0;
    round_idx_c = idx_q;
    key_shift_c = 2'd0;
    final_cap_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b0;
        if (bus.start) begin
          dir_d   = bus.mode;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        load_init_c = 1'b1;
        key_load_c  = 1'b1;
        round_idx_c = '0;
        idx_d       = '0;
        state_d     = S_ROUND;
      end
      S_ROUND: begin
        round_en_c = ~bus.hold;
        if (round_en_c) begin
          key_shift_c = shift_amt(dir_q, idx_q);
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_FINAL;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_FINAL: begin
        final_cap_c = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = busy_c;
  assign bus.out_valid = out_valid_c;
  assign bus.load_init = load_init_c;
  assign bus.key_load  = key_load_c;
  assign bus.round_en  = round_en_c;
  assign bus.round_idx = round_idx_c;
  assign bus.key_shift = key_shift_c;
  assign bus.key_dir   = dir_q;
  assign bus.final_cap = final_cap_c;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Directed bench for des_round_ctrl: reset values, encrypt/decrypt schedules,
// hold stall, DONE backpressure, start during ROUND, async reset mid-run.
// Inputs change 1ns after the rising edge; outputs are checked in that window.
module tb_des_round_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  des_round_ctrl_if #(.IDX_W(4)) bus ();

  des_round_ctrl #(.ROUNDS(16), .IDX_W(4)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // hand-derived rotate tables
  logic [1:0] enc_tab [16];
  logic [1:0] dec_tab [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete block. hold_at/poke_at < 0 disables that feature.
  task automatic run_block(input logic m, input int hold_at, input int hold_len,
                           input int poke_at, input int ready_wait);
    logic [1:0] exp_sh;
    bus.mode  = m;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("load_init", 32'(bus.load_init), 1);
    chk("key_load", 32'(bus.key_load), 1);
    chk("load_round_en", 32'(bus.round_en), 0);
    chk("load_idx", 32'(bus.round_idx), 0);
    chk("load_busy", 32'(bus.busy), 1);
    chk("load_in_ready", 32'(bus.in_ready), 0);
    chk("load_key_dir", 32'(bus.key_dir), 32'(m));
    for (int i = 0; i < 16; i++) begin
      tick();
      bus.start     = 1'b0;
      bus.mode      = m;
      bus.out_ready = 1'b0;
      if (i == hold_at) begin
        bus.hold = 1'b1;
        for (int h = 0; h < hold_len; h++) begin
          #1;
          chk("hold_round_en", 32'(bus.round_en), 0);
          chk("hold_idx", 32'(bus.round_idx), 32'(i));
          chk("hold_key_shift", 32'(bus.key_shift), 0);
          tick();
        end
        bus.hold = 1'b0;
        #1;
      end
      exp_sh = m ? dec_tab[i] : enc_tab[i];
      chk("round_en", 32'(bus.round_en), 1);
      chk("round_idx", 32'(bus.round_idx), 32'(i));
      chk("key_shift", 32'(bus.key_shift), 32'(exp_sh));
      chk("key_dir", 32'(bus.key_dir), 32'(m));
      chk("round_no_load", 32'(bus.load_init), 0);
      chk("round_no_final", 32'(bus.final_cap), 0);
      if (i == poke_at) begin
        bus.start     = 1'b1;
        bus.mode      = ~m;
        bus.out_ready = 1'b1;
      end
    end
    tick();
    bus.start     = 1'b0;
    bus.mode      = m;
    bus.out_ready = 1'b0;
    chk("final_cap", 32'(bus.final_cap), 1);
    chk("final_round_en", 32'(bus.round_en), 0);
    chk("final_no_valid", 32'(bus.out_valid), 0);
    tick();
    chk("out_valid", 32'(bus.out_valid), 1);
    chk("done_final_cap", 32'(bus.final_cap), 0);
    chk("done_busy", 32'(bus.busy), 1);
    for (int d = 0; d < ready_wait; d++) begin
      bus.start = 1'b1;
      tick();
      chk("stall_valid", 32'(bus.out_valid), 1);
      chk("stall_in_ready", 32'(bus.in_ready), 0);
      chk("stall_no_load", 32'(bus.load_init), 0);
    end
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    chk("idle_in_ready", 32'(bus.in_ready), 1);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_valid", 32'(bus.out_valid), 0);
    tick();
    chk("idle_no_accept", 32'(bus.load_init), 0);
    chk("idle_stays", 32'(bus.in_ready), 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    enc_tab = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    dec_tab = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    bus.start     = 1'b0;
    bus.mode      = 1'b0;
    bus.hold      = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_load_init", 32'(bus.load_init), 0);
    chk("rst_round_en", 32'(bus.round_en), 0);
    chk("rst_idx", 32'(bus.round_idx), 0);
    chk("rst_key_dir", 32'(bus.key_dir), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    rst_n = 1'b1;
    tick();

    // plain encrypt, plain decrypt
    run_block(1'b0, -1, 0, -1, 0);
    run_block(1'b1, -1, 0, -1, 0);
    // 3-cycle hold at round 5
    run_block(1'b0, 5, 3, -1, 0);
    // start/mode flip and early out_ready at round 7, then 4 cycles of DONE backpressure
    run_block(1'b1, -1, 0, 7, 4);

    // asynchronous reset while in round 9 of a decrypt
    bus.mode  = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("pre_rst_idx", 32'(bus.round_idx), 9);
    chk("pre_rst_round_en", 32'(bus.round_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_round_en", 32'(bus.round_en), 0);
    chk("arst_idx", 32'(bus.round_idx), 0);
    chk("arst_in_ready", 32'(bus.in_ready), 1);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_key_dir", 32'(bus.key_dir), 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("arst_no_result", 32'({bus.final_cap, bus.out_valid, bus.busy}), 0);
    end
    run_block(1'b0, -1, 0, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_round_ctrl.md
Name: des_round_ctrl

Overview:
- Sequencing FSM for the DES iterative round datapath.
- Accepts a start request and issues the one-cycle initial load to the L/R half-registers and key schedule register.
- Steps 16 rounds with round-enable and per-round key-shift control, then raises a final-capture strobe and holds a valid/ready output handshake.
- Sits between the block-level command interface and the L/R registers, f-function and key schedule.

Parameters:
- ROUNDS, 16, number of Feistel rounds sequenced. Must be ≤ 2^IDX_W. The shift table is defined for indices 0..15.
- IDX_W, 4, width of the round_idx output.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request to process one block; accepted only when in_ready=1.
- mode  input  1  0=encrypt, 1=decrypt; sampled with an accepted start.
- hold  input  1  pauses round stepping while in ROUND.
- out_ready  input  1  downstream accepts the result.
- in_ready  output  1  controller idle, able to accept start.
- busy  output  1  high in any state other than IDLE.
- load_init  output  1  one-cycle strobe: L/R registers load L0/R0.
- key_load  output  1  one-cycle strobe: key schedule loads the permuted key (PC-1).
- round_en  output  1  enable for L/R and key registers; one round per high cycle.
- round_idx  output  IDX_W  index of the round executing this cycle (0..ROUNDS-1).
- key_shift  output  2  rotate amount for this round (0, 1 or 2).
- key_dir  output  1  rotate direction: 0=left (encrypt), 1=right (decrypt).
- final_cap  output  1  one-cycle strobe: output register captures R16||L16.
- out_valid  output  1  result held valid until out_ready.

Behaviour:
- States: IDLE, LOAD, ROUND, FINAL, DONE. Reset state is IDLE.
- Reset values: in_ready=1; all other outputs 0; round_idx=0; mode latch=0.
- Asynchronous reset asserted in any state forces IDLE immediately and drops all strobes the same instant. No partial result is ever flagged valid.
- IDLE: in_ready=1. On start=1 at a clock edge, latch mode into key_dir and go to LOAD. start=0 keeps IDLE.
- start is ignored in all non-IDLE states. No queuing.
- LOAD (exactly 1 cycle): load_init=1, key_load=1, round_en=0, round_idx=0. hold is ignored. Next state is ROUND.
- ROUND: round_en = ~hold.
  - On an edge with round_en=1: if round_idx=ROUNDS-1, go to FINAL and clear round_idx to 0; otherwise increment round_idx.
  - hold=1 freezes round_idx and state. round_en=0 and key_shift=0 while held.
- key_shift, valid when round_en=1, else 0:
  - Encrypt (left): 1 for idx in {0,1,8,15}, else 2.
  - Decrypt (right): 0 for idx 0; 1 for idx in {1,8,15}; else 2.
- load_init and round_en are never high in the same cycle. The downstream register priority (load over enable) is never exercised by this block.
- FINAL (exactly 1 cycle): final_cap=1, round_en=0. Next state is DONE.
- DONE: out_valid=1, busy=1. On out_ready=1 at an edge, go to IDLE, and in_ready=1 next cycle.
  - out_ready high before DONE has no effect.
  - start in the cycle out_valid&out_ready completes is not accepted; start must be presented in IDLE.
- Latency with hold=0: start accepted at edge E0.
  - LOAD occupies cycle E0→E1.
  - Rounds 0..15 occupy E1..E17.
  - FINAL occupies E17→E18.
  - out_valid rises after E18.
  - Accept to out_valid is 18 cycles.
- Arithmetic: round_idx counts modulo ROUNDS, never beyond ROUNDS-1. Mode changes after acceptance have no effect until the next start.

Test Plan:
- Reset, then start=1, mode=0, hold=0 for 1 cycle -> load_init/key_load high 1 cycle. round_en high 16 consecutive cycles with round_idx 0..15 and key_shift 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, key_dir=0. final_cap 1 cycle, then out_valid after 18 cycles.
- mode=1 run -> key_dir=1, key_shift 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- hold=1 for 3 cycles at round_idx=5 -> round_en=0, idx stays 5, key_shift=0. Resume at idx 5; out_valid arrives at cycle 21.
- out_ready=0 for 4 cycles in DONE -> out_valid stays 1 and start is ignored. out_ready=1 -> IDLE, in_ready=1 next cycle.
- start pulsed during ROUND idx 7 with mode flipped -> no effect on sequence, key_dir or timing.
- rst=0 asynchronously at round_idx=9 -> immediate IDLE with round_en=0 and round_idx=0. No final_cap or out_valid. A new start runs a full, correct 16-round sequence.
